// File: rtl/approx_product_accumulator.sv
// Sums N_ACC approximate products per block with saturation; flush emits a partial block early.
// Latency: one cycle from the completing accept to acc_valid. Backpressure: in_ready = en, and products offered while en is low are dropped.
module approx_product_accumulator #(
   parameter int N_ACC = 4,
   parameter int ACC_W = 12
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [7:0]       prod_in,
   input  logic             prod_valid,
   input  logic             flush,
   output logic             in_ready,
   output logic [ACC_W-1:0] acc_out,
   output logic             acc_valid,
   output logic [7:0]       acc_cnt,
   output logic             sat,
   output logic             busy
);

   typedef enum logic {IDLE, ACCUM} state_t;

   localparam logic [7:0]       N_ACC_C = 8'(N_ACC);
   localparam logic [ACC_W-1:0] SUM_MAX = '1;

   state_t           state_q, state_d;
   logic [ACC_W-1:0] sum_q, sum_d;
   logic [7:0]       cnt_q, cnt_d;
   logic             sticky_q, sticky_d;
   logic [ACC_W-1:0] acc_out_q, acc_out_d;
   logic [7:0]       acc_cnt_q, acc_cnt_d;
   logic             sat_q, sat_d;
   logic             acc_valid_q, acc_valid_d;

   logic             accept;
   logic             done;
   logic [ACC_W:0]   add_ext;
   logic [ACC_W-1:0] add_sum;

   assign in_ready  = en;
   assign accept    = prod_valid & en;
   assign busy      = (state_q == ACCUM);
   assign acc_out   = acc_out_q;
   assign acc_cnt   = acc_cnt_q;
   assign sat       = sat_q;
   assign acc_valid = acc_valid_q;

   // Extra carry bit flags overflow; the sum then clamps to all-ones.
   assign add_ext = {1'b0, sum_q} + (ACC_W+1)'(prod_in);
   assign add_sum = add_ext[ACC_W] ? SUM_MAX : add_ext[ACC_W-1:0];

   always_comb begin
      state_d     = state_q;
      sum_d       = sum_q;
      cnt_d       = cnt_q;
      sticky_d    = sticky_q;
      acc_out_d   = acc_out_q;
      acc_cnt_d   = acc_cnt_q;
      sat_d       = sat_q;
      acc_valid_d = 1'b0;
      done        = 1'b0;

      if (en) begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  sum_d    = ACC_W'(prod_in);
                  cnt_d    = 8'd1;
                  sticky_d = 1'b0;
                  state_d  = ACCUM;
                  done     = (N_ACC_C == 8'd1);
               end
            end
            ACCUM: begin
               if (accept) begin
                  sum_d    = add_sum;
                  cnt_d    = cnt_q + 8'd1;
                  sticky_d = sticky_q | add_ext[ACC_W];
                  done     = (cnt_d == N_ACC_C) | flush;
               end else if (flush) begin
                  done = 1'b1;
               end
            end
            default: state_d = IDLE;
         endcase
      end

      // Publish the block and clear the running state so the next accept starts fresh.
      if (done) begin
         acc_out_d   = sum_d;
         acc_cnt_d   = cnt_d;
         sat_d       = sticky_d;
         acc_valid_d = 1'b1;
         state_d     = IDLE;
         sum_d       = '0;
         cnt_d       = 8'd0;
         sticky_d    = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         sum_q       <= '0;
         cnt_q       <= 8'd0;
         sticky_q    <= 1'b0;
         acc_out_q   <= '0;
         acc_cnt_q   <= 8'd0;
         sat_q       <= 1'b0;
         acc_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         cnt_q       <= cnt_d;
         sticky_q    <= sticky_d;
         acc_out_q   <= acc_out_d;
         acc_cnt_q   <= acc_cnt_d;
         sat_q       <= sat_d;
         acc_valid_q <= acc_valid_d;
      end
   end

endmodule

// File: tb/tb_approx_product_accumulator.sv
// Bench for approx_product_accumulator: two instances (ACC_W 12 and 9) on shared stimulus,
// compared every cycle against a block-list reference model plus directed constant checks.
module tb_approx_product_accumulator;

   localparam int N = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic [7:0] prod_in = 8'd0;
   logic       prod_valid = 1'b0;
   logic       flush = 1'b0;

   logic        rdy_a, vld_a, sat_a, busy_a;
   logic [11:0] out_a;
   logic [7:0]  cnt_a;
   logic        rdy_b, vld_b, sat_b, busy_b;
   logic [8:0]  out_b;
   logic [7:0]  cnt_b;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Reference model: products of the open block, and the last completed block.
   int q[$];
   int m_sum = 0;
   int m_cnt = 0;
   bit m_vld = 1'b0;

   approx_product_accumulator #(.N_ACC(N), .ACC_W(12)) dut_a (
      .clk(clk), .rst(rst), .en(en), .prod_in(prod_in), .prod_valid(prod_valid),
      .flush(flush), .in_ready(rdy_a), .acc_out(out_a), .acc_valid(vld_a),
      .acc_cnt(cnt_a), .sat(sat_a), .busy(busy_a));

   approx_product_accumulator #(.N_ACC(N), .ACC_W(9)) dut_b (
      .clk(clk), .rst(rst), .en(en), .prod_in(prod_in), .prod_valid(prod_valid),
      .flush(flush), .in_ready(rdy_b), .acc_out(out_b), .acc_valid(vld_b),
      .acc_cnt(cnt_b), .sat(sat_b), .busy(busy_b));

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic int clampv(input int v, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (v > mx) ? mx : v;
   endfunction

   task automatic model_reset();
      q.delete();
      m_sum = 0;
      m_cnt = 0;
      m_vld = 1'b0;
   endtask

   task automatic model_step(input bit e, input bit pv, input int p, input bit fl);
      bit open;
      m_vld = 1'b0;
      if (e) begin
         open = (q.size() > 0);
         if (pv) q.push_back(p);
         if (q.size() == N || (fl && open)) begin
            m_sum = 0;
            foreach (q[i]) m_sum += q[i];
            m_cnt = q.size();
            m_vld = 1'b1;
            q.delete();
         end
      end
   endtask

   task automatic check_all();
      chk("in_ready_a", rdy_a, en);
      chk("in_ready_b", rdy_b, en);
      chk("valid_a", vld_a, m_vld);
      chk("valid_b", vld_b, m_vld);
      chk("busy_a", busy_a, q.size() > 0);
      chk("busy_b", busy_b, q.size() > 0);
      chk("out_a", out_a, clampv(m_sum, 12));
      chk("out_b", out_b, clampv(m_sum, 9));
      chk("cnt_a", cnt_a, m_cnt);
      chk("cnt_b", cnt_b, m_cnt);
      chk("sat_a", sat_a, m_sum > 4095);
      chk("sat_b", sat_b, m_sum > 511);
   endtask

   task automatic step(input logic e, input logic pv, input logic [7:0] p, input logic fl);
      en = e;
      prod_valid = pv;
      prod_in = p;
      flush = fl;
      @(posedge clk);
      cyc++;
      model_step(e, pv, int'(p), fl);
      #1;
      check_all();
   endtask

   task automatic do_reset();
      prod_valid = 1'b0;
      flush = 1'b0;
      #2 rst = 1'b0;
      model_reset();
      #1 check_all();
      @(posedge clk);
      cyc++;
      #1 check_all();
      #3 rst = 1'b1;
   endtask

   initial begin
      int vcyc[$];

      // Defaults straight out of reset.
      do_reset();
      chk("rst_out", out_a, 0);
      chk("rst_busy", busy_a, 0);

      // 9+49+27+169 = 254, one-cycle valid pulse.
      step(1, 1, 8'd9, 0);
      step(1, 1, 8'd49, 0);
      step(1, 1, 8'd27, 0);
      step(1, 1, 8'd169, 0);
      chk("basic_out", out_a, 254);
      chk("basic_cnt", cnt_a, 4);
      chk("basic_vld", vld_a, 1);
      step(1, 0, 8'd0, 0);
      chk("basic_pulse_end", vld_a, 0);

      // Enable low mid-block drops the 225s and freezes busy.
      step(1, 1, 8'd3, 0);
      step(1, 1, 8'd4, 0);
      step(0, 1, 8'd225, 0);
      chk("hold_busy", busy_a, 1);
      step(0, 1, 8'd225, 1);
      chk("hold_vld", vld_a, 0);
      step(1, 1, 8'd5, 0);
      step(1, 1, 8'd6, 0);
      chk("hold_out", out_a, 18);

      // Flush without a product, flush with a product, flush while idle.
      step(1, 1, 8'd10, 0);
      step(1, 1, 8'd20, 0);
      step(1, 0, 8'd0, 1);
      chk("flush_out", out_a, 30);
      chk("flush_cnt", cnt_a, 2);
      chk("flush_busy", busy_a, 0);
      step(1, 1, 8'd7, 0);
      step(1, 1, 8'd8, 1);
      chk("flushacc_out", out_a, 15);
      chk("flushacc_cnt", cnt_a, 2);
      step(1, 0, 8'd0, 1);
      chk("flush_idle_vld", vld_a, 0);

      // Saturation on the 9-bit instance, then a clean block clears sat.
      step(1, 1, 8'd255, 0);
      step(1, 1, 8'd255, 0);
      step(1, 1, 8'd10, 0);
      step(1, 1, 8'd1, 0);
      chk("sat9_out", out_b, 511);
      chk("sat9_flag", sat_b, 1);
      chk("sat12_out", out_a, 521);
      step(1, 1, 8'd1, 0);
      step(1, 1, 8'd1, 0);
      step(1, 1, 8'd1, 0);
      step(1, 1, 8'd1, 0);
      chk("unsat9_out", out_b, 4);
      chk("unsat9_flag", sat_b, 0);

      // Reset mid-block discards the partial sum.
      step(1, 1, 8'd50, 0);
      step(1, 1, 8'd60, 0);
      do_reset();
      chk("midrst_out", out_a, 0);
      chk("midrst_vld", vld_a, 0);
      step(1, 0, 8'd0, 0);
      chk("midrst_novld", vld_a, 0);
      step(1, 1, 8'd5, 0);
      step(1, 1, 8'd5, 0);
      step(1, 1, 8'd5, 0);
      step(1, 1, 8'd5, 0);
      chk("postrst_out", out_a, 20);

      // Back-to-back blocks with no bubble.
      step(1, 0, 8'd0, 0);
      for (int i = 0; i < 8; i++) begin
         step(1, 1, 8'd10, 0);
         if (vld_a === 1'b1) begin
            vcyc.push_back(cyc);
            chk("b2b_out", out_a, 40);
         end
      end
      chk("b2b_count", vcyc.size(), 2);
      if (vcyc.size() == 2) chk("b2b_gap", vcyc[1] - vcyc[0], 4);

      // Random traffic against the model.
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
              8'($urandom_range(0, 255)), $urandom_range(0, 9) == 0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/approx_product_accumulator.md
APPROX_PRODUCT_ACCUMULATOR -- requirements
Module: approx_product_accumulator

Interface
REQ-001 SHALL have parameter N_ACC, default 4: products summed per block; legal range 1..255.
REQ-002 SHALL have parameter ACC_W, default 12: accumulator and result width; legal range 8..24.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port en, input, 1: stage enable; low = hold all state (clock-gating equivalent).
REQ-006 SHALL have port prod_in, input, 8: approximate product from the upstream 4-bit approximate multiplier Y output.
REQ-007 SHALL have port prod_valid, input, 1: prod_in is valid this cycle.
REQ-008 SHALL have port flush, input, 1: emit partial sum of the current block early.
REQ-009 SHALL have port in_ready, output, 1: product is accepted this cycle.
REQ-010 SHALL have port acc_out, output, ACC_W: last completed block sum.
REQ-011 SHALL have port acc_valid, output, 1: one-cycle pulse; acc_out was updated.
REQ-012 SHALL have port acc_cnt, output, 8: number of products in the last completed block.
REQ-013 SHALL have port sat, output, 1: last completed block saturated.
REQ-014 SHALL have port busy, output, 1: a block is partially accumulated.

Function
REQ-015 SHALL implement FSM states IDLE and ACCUM; busy = (state == ACCUM).
REQ-016 SHALL drive in_ready = en, combinationally; accept = prod_valid & in_ready.
REQ-017 SHALL hold state, the running sum, count, sticky-saturation flag and all outputs unchanged when en = 0, except that acc_valid SHALL be 0.
REQ-018 IDLE + accept SHALL set sum = prod_in, cnt = 1, sticky = 0; if N_ACC == 1, complete immediately (REQ-021), else go to ACCUM.
REQ-019 ACCUM + accept SHALL set sum = sum + prod_in and cnt = cnt + 1.
REQ-020 The addition SHALL saturate at 2^ACC_W-1; sticky SHALL be set on any saturating add and SHALL stay set for the rest of the block.
REQ-021 The block SHALL complete on the accept that makes cnt == N_ACC; on the next edge acc_out = new sum, acc_cnt = N_ACC, sat = sticky, acc_valid = 1 for one cycle, and state = IDLE.
REQ-022 ACCUM + en + flush with no accept SHALL complete with the current sum and cnt, then return to IDLE.
REQ-023 ACCUM + en + flush + accept SHALL include prod_in in the sum, then complete with cnt + 1.
REQ-024 flush in IDLE SHALL be ignored, with no acc_valid.
REQ-025 Latency SHALL be one cycle from the completing accept to acc_valid; there SHALL be no bubble, so a product accepted in the acc_valid cycle starts the next block.
REQ-026 prod_valid while en = 0 SHALL be dropped, not buffered.

Reset
REQ-027 rst low SHALL asynchronously force state = IDLE, sum = 0, cnt = 0, sticky = 0, acc_out = 0, acc_cnt = 0, sat = 0, acc_valid = 0.
REQ-028 A reset asserted mid-block SHALL discard the partial sum, and no acc_valid SHALL follow.
REQ-029 After rst deasserts, the first accepted product SHALL start a fresh block.

Verification
REQ-030 Bench SHALL cover: defaults; products 9, 49, 27, 169 with en = 1 -> one cycle after the 4th accept, acc_out = 254, acc_cnt = 4, sat = 0, acc_valid high exactly 1 cycle.
REQ-031 Bench SHALL cover: en = 0 for 2 cycles mid-block while prod_valid = 1 with 225 -> no change to sum or busy; after en returns, the sum completes excluding 225.
REQ-032 Bench SHALL cover: products 10, 20, then flush with no valid -> acc_out = 30, acc_cnt = 2, busy = 0 next cycle.
REQ-033 Bench SHALL cover: ACC_W = 9, products 255, 255, 10, 1 -> acc_out = 511, sat = 1; the next block of 1, 1, 1, 1 -> acc_out = 4, sat = 0.
REQ-034 Bench SHALL cover: rst pulsed low after 2 of 4 products -> all outputs 0, no acc_valid; products 5, 5, 5, 5 -> acc_out = 20.
REQ-035 Bench SHALL cover: back-to-back blocks, valid every cycle for 8 products of 10 -> acc_valid on 2 cycles exactly 4 apart, each acc_out = 40.
